wb_des_ctrl: RTL and testbench

WB_DES_CTRL -- requirements
Module: wb_des_ctrl

---
 rtl/wb_des_ctrl_pkg.sv | 48 ++++
 rtl/wb_des_ctrl_if.sv | 21 ++
 rtl/wb_des_ctrl_sync_chain.sv | 29 ++
 rtl/wb_des_ctrl.sv | 143 ++++++++++++++
 tb/tb_wb_des_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_des_ctrl_pkg.sv
// Shared constants and types for the design-select controller: register offsets,
// CTRL field positions, synchronizer depths and the Wishbone address decoder.
package des_ctrl_pkg;

  localparam logic [3:0]  OFF_CTRL     = 4'h0;
  localparam logic [3:0]  OFF_IN       = 4'h4;
  localparam logic [3:0]  OFF_OUT      = 4'h8;
  localparam logic [3:0]  OFF_RST      = 4'hC;
  localparam logic [31:0] WINDOW_BYTES = 32'd16;

  localparam int CTRL_OVR_EN_BIT = 0;
  localparam int CTRL_HOLD_BIT   = 1;
  localparam int CTRL_SEL_LSB    = 8;
  localparam int CTRL_SEL_MSB    = 13;

  localparam int PAD_SYNC_DEPTH = 5;
  localparam int OUT_SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_IN,
    REG_OUT,
    REG_RST,
    REG_NONE
  } reg_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wb_state_e;

  // Byte offset from BASE_ADDR; anything past the 16-byte window decodes to REG_NONE.
  function automatic reg_e decode_reg(input logic [31:0] offset);
    reg_e r;
    r = REG_NONE;
    if (offset < WINDOW_BYTES) begin
      case ({offset[3:2], 2'b00})
        OFF_CTRL: r = REG_CTRL;
        OFF_IN:   r = REG_IN;
        OFF_OUT:  r = REG_OUT;
        OFF_RST:  r = REG_RST;
        default:  r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_des_ctrl_if.sv
// Wishbone classic slave bus bundle for wb_des_ctrl; names follow the slave-side view.
interface wb_des_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_des_ctrl_sync_chain.sv
// Parameterized-depth flop chain used to bring asynchronous pad and design signals
// into the wb_clk_i domain; every stage clears on synchronous reset.
module sync_chain #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge clk_i) begin
        if (srst_i) stage_q[gi] <= '0;
        else        stage_q[gi] <= d_i;
      end
    end else begin : g_rest
      always_ff @(posedge clk_i) begin
        if (srst_i) stage_q[gi] <= '0;
        else        stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/wb_des_ctrl.sv
// Wishbone-controlled design-select mux with software reset pulse generator.
// Define DES_OUT_READBACK_EN to synchronize des_out and return it in the OUT register.
module wb_des_ctrl
  import des_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  wb_des_ctrl_if.slave wbs,
  input  logic [11:0]  pad_in,
  input  logic [5:0]   pad_sel,
  input  logic         pad_hold,
  input  logic         pad_reset,
  input  logic [11:0]  des_out,
  output logic [11:0]  des_in,
  output logic [5:0]   des_sel,
  output logic         des_hold,
  output logic         des_reset
);
  localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_CYCLES);

  wb_state_e   state_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data_d;
  logic        ovr_en_q;
  logic        hold_q;
  logic [5:0]  sel_q;
  logic [11:0] in_q;
  logic [7:0]  pulse_cnt_q;
  logic [7:0]  pulse_cnt_d;
  logic [31:0] offset;
  reg_e        reg_sel;
  logic        req;
  logic        wr_en;
  logic        pulse_active;
  logic        sync_reset;
  logic [11:0] out_rb;
  logic        unused_ok;

  assign offset       = wbs.wbs_adr_i - BASE_ADDR;
  assign reg_sel      = decode_reg(offset);
  assign req          = wbs.wbs_stb_i & wbs.wbs_cyc_i;
  // Writes commit on the edge that closes the ack cycle.
  assign wr_en        = (state_q == ST_ACK) & req & wbs.wbs_we_i;
  assign pulse_active = (pulse_cnt_q != 8'd0);

  always_comb begin
    rd_data_d = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data_d[CTRL_OVR_EN_BIT]            = ovr_en_q;
        rd_data_d[CTRL_HOLD_BIT]              = hold_q;
        rd_data_d[CTRL_SEL_MSB:CTRL_SEL_LSB]  = sel_q;
      end
      REG_IN:  rd_data_d[11:0] = in_q;
      REG_OUT: rd_data_d[11:0] = out_rb;
      REG_RST: rd_data_d[0]    = pulse_active;
      default: rd_data_d       = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_ACK;
            dat_q   <= rd_data_d;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          dat_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = (state_q == ST_ACK);
  assign wbs.wbs_dat_o = dat_q;

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (wr_en && reg_sel == REG_RST) pulse_cnt_d = PULSE_LOAD;
    else if (pulse_active)           pulse_cnt_d = pulse_cnt_q - 8'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovr_en_q    <= 1'b0;
      hold_q      <= 1'b0;
      sel_q       <= '0;
      in_q        <= '0;
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      if (wr_en && reg_sel == REG_CTRL) begin
        if (wbs.wbs_sel_i[0]) begin
          ovr_en_q <= wbs.wbs_dat_i[CTRL_OVR_EN_BIT];
          hold_q   <= wbs.wbs_dat_i[CTRL_HOLD_BIT];
        end
        if (wbs.wbs_sel_i[1]) sel_q <= wbs.wbs_dat_i[CTRL_SEL_MSB:CTRL_SEL_LSB];
      end
      if (wr_en && reg_sel == REG_IN) begin
        if (wbs.wbs_sel_i[0]) in_q[7:0]  <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) in_q[11:8] <= wbs.wbs_dat_i[11:8];
      end
    end
  end

  sync_chain #(.DEPTH(PAD_SYNC_DEPTH), .WIDTH(1)) u_pad_reset_sync (
    .clk_i  (wb_clk_i),
    .srst_i (wb_rst_i),
    .d_i    (pad_reset),
    .q_o    (sync_reset)
  );

`ifdef DES_OUT_READBACK_EN
  sync_chain #(.DEPTH(OUT_SYNC_DEPTH), .WIDTH(12)) u_des_out_sync (
    .clk_i  (wb_clk_i),
    .srst_i (wb_rst_i),
    .d_i    (des_out),
    .q_o    (out_rb)
  );
  assign unused_ok = ^{wbs.wbs_dat_i[31:14], wbs.wbs_sel_i[3:2]};
`else
  assign out_rb    = '0;
  assign unused_ok = ^{wbs.wbs_dat_i[31:14], wbs.wbs_sel_i[3:2], des_out};
`endif

  // Override path is a pure combinational mux so pad signals pass unregistered.
  assign des_in    = ovr_en_q ? in_q   : pad_in;
  assign des_sel   = ovr_en_q ? sel_q  : pad_sel;
  assign des_hold  = ovr_en_q ? hold_q : pad_hold;
  assign des_reset = sync_reset | pulse_active;

endmodule

// File: tb/tb_wb_des_ctrl.sv
// Self-checking bench for wb_des_ctrl: Wishbone reads go through an expected-value
// scoreboard; mux, pulse and synchronizer timing are checked per scenario task.
module tb_wb_des_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_IN   = BASE + 32'h4;
  localparam logic [31:0] A_OUT  = BASE + 32'h8;
  localparam logic [31:0] A_RST  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pad_in = '0;
  logic [5:0]  pad_sel = '0;
  logic        pad_hold = 1'b0;
  logic        pad_reset = 1'b0;
  logic [11:0] des_out = '0;
  logic [11:0] des_in;
  logic [5:0]  des_sel;
  logic        des_hold;
  logic        des_reset;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  wb_des_ctrl_if bus();

  wb_des_ctrl #(.BASE_ADDR(BASE), .RST_PULSE_CYCLES(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (bus),
    .pad_in    (pad_in),
    .pad_sel   (pad_sel),
    .pad_hold  (pad_hold),
    .pad_reset (pad_reset),
    .des_out   (des_out),
    .des_in    (des_in),
    .des_sel   (des_sel),
    .des_hold  (des_hold),
    .des_reset (des_reset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    tick();
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 16);
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL ack_latency adr=%h got ack=%b after %0d cycles, want ack=1 after 1", adr, bus.wbs_ack_o, n);
    end
    rdat = bus.wbs_dat_o;
    tick();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL ack_width adr=%h got ack=%b dat=%h, want ack=0 dat=0", adr, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    $display("WB we=%0d adr=%h wdat=%h sel=%b rdat=%h", we, adr, dat, sel, rdat);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_cycle(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    logic [31:0] e;
    string nm;
    exp_q.push_back(exp);
    name_q.push_back(name);
    wb_cycle(1'b0, adr, 32'h0, 4'hF, rd);
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== e) begin
      failures++;
      $display("FAIL %s got %h want %h", nm, rd, e);
    end
  endtask

  task automatic check_mux(input string name, input logic [11:0] e_in, input logic [5:0] e_sel, input logic e_hold);
    checks++;
    if (des_in !== e_in || des_sel !== e_sel || des_hold !== e_hold) begin
      failures++;
      $display("FAIL %s got in=%h sel=%h hold=%b want in=%h sel=%h hold=%b",
               name, des_in, des_sel, des_hold, e_in, e_sel, e_hold);
    end
  endtask

  task automatic test_reset();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    pad_in = 12'h5A5;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || des_reset !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b dat=%h des_reset=%b want 0 0 0", bus.wbs_ack_o, bus.wbs_dat_o, des_reset);
    end
    rst = 1'b0;
    tick();
    check_mux("reset_mux_pads", 12'h5A5, 6'h00, 1'b0);
    wb_read(A_CTRL, 32'h0, "reset_ctrl");
    wb_read(A_IN,   32'h0, "reset_in");
    wb_read(A_RST,  32'h0, "reset_rst_busy");
  endtask

  task automatic test_ctrl_rw();
    wb_write(A_CTRL, 32'h0000_2A01, 4'hF);
    check_mux("ctrl_sel_next_cycle", 12'h000, 6'h2A, 1'b0);
    wb_read(A_CTRL, 32'h0000_2A01, "ctrl_readback");
    wb_write(A_CTRL, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_CTRL, 32'h0000_3F03, "ctrl_mask");
    check_mux("ctrl_hold_override", 12'h000, 6'h3F, 1'b1);
  endtask

  task automatic test_mux();
    wb_write(A_CTRL, 32'h0, 4'hF);
    pad_in = 12'hABC; pad_sel = 6'h15; pad_hold = 1'b1;
    #1;
    check_mux("mux_pad_path", 12'hABC, 6'h15, 1'b1);
    wb_write(A_IN, 32'h0000_0123, 4'hF);
    check_mux("mux_in_write_no_ovr", 12'hABC, 6'h15, 1'b1);
    wb_write(A_CTRL, 32'h0000_0001, 4'hF);
    check_mux("mux_override", 12'h123, 6'h00, 1'b0);
    pad_in = 12'h777;
    #1;
    check_mux("mux_override_ignores_pad", 12'h123, 6'h00, 1'b0);
  endtask

  task automatic test_byte_sel_and_window();
    wb_write(A_IN, 32'h0000_00AA, 4'hF);
    wb_write(A_IN, 32'hFFFF_FF55, 4'b0001);
    wb_read(A_IN, 32'h0000_0055, "in_byte0_only");
    wb_write(A_IN, 32'hFFFF_F3FF, 4'b0010);
    wb_read(A_IN, 32'h0000_0355, "in_byte1_only");
    wb_read(BASE + 32'h20, 32'h0, "out_of_window_read");
    wb_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    wb_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_OUT, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_IN,   32'h0000_0355, "in_after_stray_writes");
    wb_read(A_CTRL, 32'h0000_0001, "ctrl_after_stray_writes");
    wb_read(A_RST,  32'h0, "rst_after_stray_writes");
  endtask

  task automatic test_out_readback();
    logic [31:0] e;
    des_out = 12'hF0F;
    repeat (3) tick();
`ifdef DES_OUT_READBACK_EN
    e = 32'h0000_0F0F;
`else
    e = 32'h0;
`endif
    wb_read(A_OUT, e, "out_readback");
  endtask

  task automatic test_back_to_back();
    int acks;
    logic prev;
    logic consecutive;
    tick();
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = A_CTRL; bus.wbs_sel_i = 4'hF;
    acks = 0; prev = 1'b0; consecutive = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) begin
        acks++;
        if (prev) consecutive = 1'b1;
      end
      prev = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    checks++;
    if (acks != 3 || consecutive) begin
      failures++;
      $display("FAIL back_to_back got acks=%0d consecutive=%b want acks=3 consecutive=0", acks, consecutive);
    end
    $display("WB held-strobe read adr=%h acks=%0d", A_CTRL, acks);
    tick();
  endtask

  task automatic test_rst_pulse();
    int cnt;
    wb_write(A_RST, 32'h1, 4'hF);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (des_reset !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL pulse_length got %0d cycles want 16", cnt);
    end
    wb_write(A_RST, 32'h0, 4'h0);
    cnt = 0;
    while (cnt < 10 && des_reset === 1'b1) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 10) begin
      failures++;
      $display("FAIL pulse_before_rewrite got %0d cycles want 10", cnt);
    end
    wb_write(A_RST, 32'h1, 4'hF);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (des_reset !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL pulse_extended got %0d cycles want 16", cnt);
    end
    wb_write(A_RST, 32'h1, 4'hF);
    wb_read(A_RST, 32'h1, "rst_busy_during_pulse");
    repeat (20) tick();
    wb_read(A_RST, 32'h0, "rst_idle_after_pulse");
  endtask

  task automatic test_pad_reset();
    int n;
    int first_hi;
    int hi_cnt;
    tick();
    pad_reset = 1'b1;
    tick();
    pad_reset = 1'b0;
    n = 1; first_hi = 0; hi_cnt = 0;
    while (n <= 12) begin
      if (des_reset === 1'b1) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = n;
      end
      tick();
      n++;
    end
    checks++;
    if (first_hi != 5 || hi_cnt != 1) begin
      failures++;
      $display("FAIL pad_reset_sync got first=%0d width=%0d want first=5 width=1", first_hi, hi_cnt);
    end
  endtask

  task automatic test_reset_abort();
    logic bad;
    wb_write(A_RST, 32'h1, 4'hF);
    repeat (3) tick();
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_CTRL;
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (des_reset !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_abort got des_reset=%b ack=%b dat=%h want 0 0 0", des_reset, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (des_reset !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_after got des_reset=%b want 0", des_reset);
    end
    wb_read(A_RST,  32'h0, "rst_cleared_by_reset");
    wb_read(A_CTRL, 32'h0, "ctrl_cleared_by_reset");
    wb_read(A_IN,   32'h0, "in_cleared_by_reset");
  endtask

  initial begin
    test_reset();
    test_ctrl_rw();
    test_mux();
    test_byte_sel_and_window();
    test_out_readback();
    test_back_to_back();
    test_rst_pulse();
    test_pad_reset();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
